// File: rtl/latch_q_monitor.sv
// latch_q_monitor: re-times a latch q/q_n pair into clk, debounces it and reports accepted transitions as events.
module latch_q_monitor #(
    parameter int STABLE_CNT = 4,
    parameter int ERR_CNT    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q,
    input  logic             q_n,
    input  logic             clr_err,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             evt_rise,
    output logic             q_stable,
    output logic [CNT_W-1:0] trans_cnt,
    output logic             err,
    output logic             ovf
);
    localparam int RW = $clog2(STABLE_CNT + 1);
    localparam int BW = $clog2(ERR_CNT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CNT);
    localparam logic [BW-1:0] BAD_MAX = BW'(ERR_CNT);

    typedef enum logic [1:0] {LOCKED, SETTLING, INVALID} state_t;

    state_t          state, state_nxt;
    logic [1:0]      q_sync, qn_sync;
    logic [RW-1:0]   run, run_nxt;
    logic [BW-1:0]   bad, bad_nxt;
    logic            qs, qns, accept, drop, err_set;

    assign qs  = q_sync[1];
    assign qns = qn_sync[1];

    always_comb begin
        state_nxt = state;
        run_nxt   = '0;
        bad_nxt   = '0;
        accept    = 1'b0;
        if (qs == qns) begin
            state_nxt = INVALID;
            bad_nxt   = state != INVALID ? BW'(1) : bad == BAD_MAX ? bad : bad + BW'(1);
        end else if (qs == q_stable) begin
            state_nxt = LOCKED;
        end else begin
            // entering from LOCKED or INVALID counts the first sighting as run=1
            run_nxt   = state == SETTLING ? run + RW'(1) : RW'(1);
            accept    = run_nxt == RUN_MAX;
            state_nxt = accept ? LOCKED : SETTLING;
        end
    end

    assign drop    = accept && evt_valid && !evt_ready;
    assign err_set = bad_nxt == BAD_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync    <= 2'b00;
            qn_sync   <= 2'b11;
            state     <= LOCKED;
            run       <= '0;
            bad       <= '0;
            q_stable  <= 1'b0;
            trans_cnt <= '0;
            evt_valid <= 1'b0;
            evt_rise  <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            q_sync    <= {q_sync[0], q};
            qn_sync   <= {qn_sync[0], q_n};
            state     <= state_nxt;
            run       <= accept ? '0 : run_nxt;
            bad       <= bad_nxt;
            q_stable  <= accept ? qs : q_stable;
            trans_cnt <= accept ? trans_cnt + CNT_W'(1) : trans_cnt;
            // a dropped event leaves the pending one untouched
            evt_valid <= accept || (evt_valid && !evt_ready);
            evt_rise  <= accept && !drop ? qs : evt_rise;
            err       <= err_set || (err && !clr_err);
            ovf       <= drop || (ovf && !clr_err);
        end
    end
endmodule

// File: tb/tb_latch_q_monitor.sv
// tb_latch_q_monitor: scoreboard bench for latch_q_monitor with default parameters.
module tb_latch_q_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       q = 1'b0;
    logic       q_n = 1'b1;
    logic       clr_err = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_rise, q_stable, err, ovf;
    logic [7:0] trans_cnt;
    logic [7:0] exp_cnt;
    logic       v;
    bit         sb[$];
    int         vectors = 0;
    int         miscompares = 0;

    latch_q_monitor dut (
        .clk(clk), .rst_n(rst_n), .q(q), .q_n(q_n), .clr_err(clr_err),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_rise(evt_rise),
        .q_stable(q_stable), .trans_cnt(trans_cnt), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic qv, input logic qnv);
        @(posedge clk);
        #1;
        q = qv;
        q_n = qnv;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        q = 1'b0; q_n = 1'b1; evt_ready = 1'b0; clr_err = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_clr;
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    always @(negedge clk)
        if (rst_n && evt_valid && evt_ready) begin
            if (sb.size() == 0) check("evt_unexpected", evt_valid, 1'b0);
            else check("evt_rise_sb", evt_rise, sb.pop_front());
        end

    initial begin
        // reset asserted mid-settling, then release with q still high
        do_reset;
        evt_ready = 1'b1;
        drive(1'b1, 1'b0);
        cycles(3);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_q_stable", q_stable, 0);
        check("rst_trans_cnt", trans_cnt, 0);
        check("rst_err", err, 0);
        cycles(3);
        @(negedge clk);
        check("rst_hold_q_stable", q_stable, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(1'b1);
        cycles(12);
        @(negedge clk);
        check("relock_q_stable", q_stable, 1);
        check("relock_trans_cnt", trans_cnt, 1);
        check("relock_evt_valid", evt_valid, 0);

        // rise with exact latency
        do_reset;
        evt_ready = 1'b1;
        drive(1'b1, 1'b0);
        sb.push_back(1'b1);
        cycles(5);
        @(negedge clk);
        check("rise_early_q_stable", q_stable, 0);
        check("rise_early_valid", evt_valid, 0);
        @(negedge clk);
        check("rise_q_stable", q_stable, 1);
        check("rise_valid", evt_valid, 1);
        check("rise_dir", evt_rise, 1);
        check("rise_trans_cnt", trans_cnt, 1);
        @(negedge clk);
        check("rise_valid_drop", evt_valid, 0);

        // glitch shorter than STABLE_CNT
        do_reset;
        evt_ready = 1'b1;
        drive(1'b1, 1'b0);
        @(posedge clk);
        drive(1'b0, 1'b1);
        cycles(10);
        @(negedge clk);
        check("glitch_q_stable", q_stable, 0);
        check("glitch_trans_cnt", trans_cnt, 0);
        check("glitch_valid", evt_valid, 0);

        // rails equal: err after ERR_CNT synchronised cycles
        drive(1'b1, 1'b1);
        cycles(9);
        @(negedge clk);
        check("fault_err_early", err, 0);
        @(negedge clk);
        check("fault_err_set", err, 1);
        pulse_clr;
        @(negedge clk);
        check("fault_clr_while_bad", err, 1);
        drive(1'b0, 1'b1);
        cycles(4);
        pulse_clr;
        @(negedge clk);
        check("fault_err_cleared", err, 0);
        check("fault_q_stable", q_stable, 0);
        check("fault_ovf", ovf, 0);
        check("fault_valid", evt_valid, 0);

        // backpressure: second event dropped
        do_reset;
        drive(1'b1, 1'b0);
        sb.push_back(1'b1);
        cycles(8);
        @(negedge clk);
        check("bp_valid", evt_valid, 1);
        check("bp_rise", evt_rise, 1);
        drive(1'b0, 1'b1);
        cycles(8);
        @(negedge clk);
        check("bp_rise_held", evt_rise, 1);
        check("bp_ovf", ovf, 1);
        check("bp_trans_cnt", trans_cnt, 2);
        check("bp_q_stable", q_stable, 0);
        @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_cleared", evt_valid, 0);
        pulse_clr;
        @(negedge clk);
        check("bp_ovf_cleared", ovf, 0);

        // ready coincides with the second event: it loads, no ovf
        drive(1'b1, 1'b0);
        sb.push_back(1'b1);
        cycles(8);
        @(negedge clk);
        check("bp2_valid", evt_valid, 1);
        drive(1'b0, 1'b1);
        sb.push_back(1'b0);
        cycles(5);
        #1 evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp2_valid", evt_valid, 1);
        check("bp2_rise", evt_rise, 0);
        check("bp2_ovf", ovf, 0);
        check("bp2_trans_cnt", trans_cnt, 4);
        cycles(2);

        // 256 transitions wrap the counter
        do_reset;
        evt_ready = 1'b1;
        exp_cnt = '0;
        v = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = ~v;
            drive(v, ~v);
            sb.push_back(v);
            cycles(7);
            exp_cnt++;
            if (i == 254) begin
                @(negedge clk);
                check("wrap_cnt_255", trans_cnt, exp_cnt);
            end
        end
        @(negedge clk);
        check("wrap_cnt", trans_cnt, exp_cnt);
        check("wrap_err", err, 0);
        check("wrap_ovf", ovf, 0);
        check("wrap_q_stable", q_stable, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
